word_array: RTL and testbench

WORD_ARRAY -- requirements
Module: word_array

---
 rtl/word_array_if.sv | 30 +++
 rtl/word_array.sv | 114 +++++++++++
 tb/tb_word_array.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/word_array_if.sv
// Request/response bundle for word_array: request handshake in, registered read response
// and status out.
interface word_array_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             op;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wmask;
  logic             clr;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, op, addr, wdata, wmask, clr,
    input  req_ready, rdata, rdata_valid, err, busy
  );

  modport slave (
    input  req_valid, op, addr, wdata, wmask, clr,
    output req_ready, rdata, rdata_valid, err, busy
  );
endinterface

// File: rtl/word_array.sv
// Register-based word array with bit-masked writes, one-cycle registered reads and a
// sequential clear sweep that runs after reset and on request.
module word_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  word_array_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthExt = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 256)) begin : g_depth_check
    $error("word_array: DEPTH must lie in 2..256");
  end

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [AW-1:0]    r_clr_idx;
  logic [AW-1:0]    w_clr_idx_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             r_rdata_valid;
  logic             r_err;

  logic w_req_ready;
  logic w_clr_we;
  logic w_last_idx;
  logic w_in_range;
  logic w_accept;
  logic w_wr_en;
  logic w_rd_en;

  // Addresses are widened by one bit so non-power-of-two depths can be range-checked.
  assign w_in_range = ({1'b0, bus.addr} < DepthExt);
  assign w_last_idx = (r_clr_idx == AW'(DEPTH - 1));

  always_comb begin
    w_state_next   = r_state;
    w_clr_idx_next = r_clr_idx;
    w_req_ready    = 1'b0;
    w_clr_we       = 1'b0;
    unique case (r_state)
      StClear: begin
        // clr is deliberately not looked at here: a sweep in progress always completes.
        w_clr_we = 1'b1;
        if (w_last_idx) begin
          w_state_next   = StIdle;
          w_clr_idx_next = '0;
        end else begin
          w_clr_idx_next = r_clr_idx + AW'(1);
        end
      end
      StIdle: begin
        if (bus.clr) begin
          w_state_next   = StClear;
          w_clr_idx_next = '0;
        end else begin
          w_req_ready = 1'b1;
        end
      end
      default: begin
        w_state_next   = StClear;
        w_clr_idx_next = '0;
      end
    endcase
  end

  assign w_accept = bus.req_valid & w_req_ready;
  assign w_wr_en  = w_accept & bus.op & w_in_range;
  assign w_rd_en  = w_accept & ~bus.op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= w_rd_en;
      r_err         <= w_accept & ~w_in_range;
      if (w_rd_en) begin
        r_rdata <= w_in_range ? r_mem[bus.addr] : '0;
      end
    end
  end

  // Storage carries no reset; the sweep zeroes it once reset is released.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.addr] <= (r_mem[bus.addr] & ~bus.wmask) | (bus.wdata & bus.wmask);
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.busy        = (r_state == StClear);
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_word_array.sv
// Scoreboard bench for word_array: a DEPTH=12 instance under directed and random traffic,
// plus a DEPTH=16 instance for sweep length and post-reset contents.
module tb_word_array;
  localparam int unsigned W  = 8;
  localparam int unsigned DA = 12;
  localparam int unsigned DB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_array_if #(.WIDTH(W), .DEPTH(DA)) a_if ();
  word_array_if #(.WIDTH(W), .DEPTH(DB)) b_if ();

  word_array #(.WIDTH(W), .DEPTH(DA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  word_array #(.WIDTH(W), .DEPTH(DB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct {
    int           due;
    logic         is_rd;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] model_mem [DA];
  logic [W-1:0] last_rdata = '0;
  bit           mon_en     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each cycle the response outputs must match the queue front if it is due,
  // otherwise be quiet with rdata holding its last read value.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_v;
      logic exp_e;
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        exp_v = mon_e.is_rd;
        exp_e = mon_e.err;
        if (mon_e.is_rd) last_rdata = mon_e.data;
      end
      chk("rdata_valid", a_if.rdata_valid, exp_v);
      chk("err", a_if.err, exp_e);
      if (exp_v) chk("rdata", a_if.rdata, last_rdata);
      else       chk("rdata_hold", a_if.rdata, last_rdata);
    end
  end

  task automatic model_zero();
    for (int i = 0; i < DA; i++) model_mem[i] = '0;
  endtask

  task automatic issue_a(input bit is_wr, input logic [3:0] ad, input logic [W-1:0] d,
                         input logic [W-1:0] m, input bit with_clr);
    exp_t e;
    bit   acc;
    bit   in_range;
    @(negedge clk);
    a_if.req_valid = 1'b1;
    a_if.op        = is_wr;
    a_if.addr      = ad;
    a_if.wdata     = d;
    a_if.wmask     = m;
    a_if.clr       = with_clr;
    #1;
    acc = a_if.req_ready;
    chk(with_clr ? "req_ready_under_clr" : "req_ready_idle", acc, !with_clr);
    if (acc) begin
      in_range = (ad < DA);
      if (is_wr && in_range) model_mem[ad] = (model_mem[ad] & ~m) | (d & m);
      if (!is_wr || !in_range) begin
        e.due   = cyc + 1;
        e.is_rd = !is_wr;
        e.data  = (!is_wr && in_range) ? model_mem[ad] : '0;
        e.err   = !in_range;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_if.req_valid = 1'b0;
      a_if.clr       = 1'b0;
    end
  endtask

  // clr together with a write request; clr is held for a few sweep cycles to show it is
  // ignored while clearing.
  task automatic clr_sweep_a(input int hold);
    int nbusy;
    int nbad;
    nbusy = 0;
    nbad  = 0;
    issue_a(1'b1, 4'($urandom_range(0, DA - 1)), 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) a_if.req_valid = 1'b0;
      if (i == hold) a_if.clr = 1'b0;
      if (a_if.busy) begin
        nbusy++;
        if (a_if.req_ready) nbad++;
      end
    end
    chk("clr_sweep_len", nbusy, DA);
    chk("ready_while_busy", nbad, 0);
    model_zero();
  endtask

  task automatic reset_checks();
    chk("rst_rdata", a_if.rdata, 0);
    chk("rst_rdata_valid", a_if.rdata_valid, 0);
    chk("rst_err", a_if.err, 0);
    chk("rst_req_ready", a_if.req_ready, 0);
    chk("rst_busy", a_if.busy, 1);
    chk("rst_busy_b", b_if.busy, 1);
  endtask

  // Called with rst_n low at a negedge; releases it and measures both sweep lengths.
  task automatic release_and_measure();
    int na;
    int nb;
    na = 0;
    nb = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (a_if.busy) na++;
      if (b_if.busy) nb++;
    end
    chk("sweep_len_a", na, DA);
    chk("sweep_len_b", nb, DB);
    model_zero();
    last_rdata = '0;
    mon_en     = 1'b1;
  endtask

  task automatic read_all_b();
    for (int i = 0; i <= DB; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b_rdata_valid", b_if.rdata_valid, 1);
        chk("b_rdata_zero", b_if.rdata, 0);
      end
      if (i < DB) begin
        b_if.req_valid = 1'b1;
        b_if.op        = 1'b0;
        b_if.addr      = 4'(i);
      end else begin
        b_if.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b_valid_one_cycle", b_if.rdata_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.req_valid = 1'b0; a_if.op = 1'b0; a_if.addr = '0;
    a_if.wdata = '0; a_if.wmask = '0; a_if.clr = 1'b0;
    b_if.req_valid = 1'b0; b_if.op = 1'b0; b_if.addr = '0;
    b_if.wdata = '0; b_if.wmask = '0; b_if.clr = 1'b0;
    model_zero();

    // Power-on reset and initial sweep.
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    release_and_measure();
    read_all_b();
    for (int i = 0; i < 16; i++) issue_a(1'b0, 4'(i), '0, '0, 1'b0);

    // Directed: write-then-read, masked write, out-of-range, wmask=0, streaming reads.
    issue_a(1'b1, 4'd3, 8'hA5, 8'hFF, 1'b0);
    issue_a(1'b0, 4'd3, '0, '0, 1'b0);
    issue_a(1'b1, 4'd5, 8'hFF, 8'hFF, 1'b0);
    issue_a(1'b1, 4'd5, 8'h00, 8'h0F, 1'b0);
    issue_a(1'b0, 4'd5, '0, '0, 1'b0);
    idle_a(2);
    issue_a(1'b0, 4'd13, '0, '0, 1'b0);
    idle_a(1);
    issue_a(1'b1, 4'd12, 8'h77, 8'hFF, 1'b0);
    issue_a(1'b1, 4'd3, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < DA; i++) issue_a(1'b0, 4'(i), '0, '0, 1'b0);
    idle_a(2);

    // Random traffic with occasional idles and clear sweeps.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        clr_sweep_a($urandom_range(1, 5));
      end else if (r < 13) begin
        idle_a(1);
      end else begin
        issue_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                8'($urandom), 1'b0);
      end
    end
    idle_a(3);
    chk("sb_drained", sb_q.size(), 0);

    // Read in flight into a clear, then reset at sweep index 7.
    issue_a(1'b1, 4'd1, 8'h3C, 8'hFF, 1'b0);
    issue_a(1'b0, 4'd1, '0, '0, 1'b0);
    issue_a(1'b1, 4'd2, 8'h11, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_if.req_valid = 1'b0;
        a_if.clr       = 1'b0;
      end
    end
    chk("rdata_before_reset", a_if.rdata, 8'h3C);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    reset_checks();
    sb_q.delete();
    @(negedge clk);
    release_and_measure();
    for (int i = 0; i < DA; i++) issue_a(1'b0, 4'(i), '0, '0, 1'b0);
    idle_a(3);
    chk("sb_drained_end", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
